// File: rtl/trace_monitor_if.sv
// Record drain bus of trace_monitor: FIFO head record plus valid/ready handshake.
interface trace_monitor_if;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_pc;
    logic [15:0] rec_seq;
    logic        rec_st;
    logic        rec_wr;
    logic [31:0] rec_st_addr;
    logic [31:0] rec_st_data;
    logic [4:0]  rec_wr_num;
    logic [31:0] rec_wr_data;

    modport master (
        output rec_valid, rec_pc, rec_seq, rec_st, rec_wr,
               rec_st_addr, rec_st_data, rec_wr_num, rec_wr_data,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_pc, rec_seq, rec_st, rec_wr,
               rec_st_addr, rec_st_data, rec_wr_num, rec_wr_data,
        output rec_ready
    );
endinterface

// File: rtl/trace_monitor.sv
// Retirement tracer: aligns fetch / ME / WB snoops through a stage-delay line and
// queues one record per instruction for a valid/ready consumer.
module trace_monitor #(
    parameter int ME_STAGE   = 3,
    parameter int WB_STAGE   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_INSTR  = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [31:0]      instr_addr,
    input  logic             flush,
    input  logic             st_en,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_out,
    input  logic             reg_wr_en,
    input  logic [4:0]       reg_wr_num,
    input  logic [31:0]      reg_wr_data,
    trace_monitor_if.master  rec,
    output logic             done,
    output logic             overflow,
    output logic [15:0]      drop_cnt,
    output logic [15:0]      flush_cnt
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] seq;
        logic        st;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic        wr;
        logic [4:0]  wr_num;
        logic [31:0] wr_data;
    } rec_t;

    // Registered slot k holds the instruction fetched k cycles ago
    logic        slot_v_q  [1:WB_STAGE];
    logic        slot_v_d  [1:WB_STAGE];
    logic [31:0] slot_pc_q [1:WB_STAGE];
    logic [31:0] slot_pc_d [1:WB_STAGE];
    logic        slot_st_q [1:WB_STAGE];
    logic        slot_st_d [1:WB_STAGE];
    logic [31:0] slot_sa_q [1:WB_STAGE];
    logic [31:0] slot_sa_d [1:WB_STAGE];
    logic [31:0] slot_sd_q [1:WB_STAGE];
    logic [31:0] slot_sd_d [1:WB_STAGE];

    logic        cur_v  [0:WB_STAGE];
    logic [31:0] cur_pc [0:WB_STAGE];
    logic        cur_st [0:WB_STAGE];
    logic [31:0] cur_sa [0:WB_STAGE];
    logic [31:0] cur_sd [0:WB_STAGE];
    logic [4:0]  flush_hits;

    rec_t             mem_q [0:FIFO_DEPTH-1];
    rec_t             mem_d [0:FIFO_DEPTH-1];
    rec_t             comp_rec;
    rec_t             head_q, head_d;
    logic             comp_v, deq, full, enq_try, enq, drop;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      seq_q, seq_d;
    logic             rec_valid_q, rec_valid_d;
    logic             done_q, done_d, overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [16:0]      flush_sum;

    // Current-cycle slot view: slot 0 is the fetch port; apply flush and ME capture, then shift
    always_comb begin
        flush_hits = 5'd0;
        cur_v[0]  = fetch_valid;
        cur_pc[0] = instr_addr;
        cur_st[0] = 1'b0;
        cur_sa[0] = 32'd0;
        cur_sd[0] = 32'd0;
        for (int k = 1; k <= WB_STAGE; k++) begin
            cur_v[k]  = slot_v_q[k];
            cur_pc[k] = slot_pc_q[k];
            cur_st[k] = slot_st_q[k];
            cur_sa[k] = slot_sa_q[k];
            cur_sd[k] = slot_sd_q[k];
        end
        for (int k = 0; k <= WB_STAGE; k++) begin
            if (flush && (k < ME_STAGE)) begin
                flush_hits = flush_hits + {4'd0, cur_v[k]};
                cur_v[k]   = 1'b0;
            end else if ((k == ME_STAGE) && cur_v[k] && st_en) begin
                cur_st[k] = 1'b1;
                cur_sa[k] = data_addr;
                cur_sd[k] = data_out;
            end else begin
            end
        end
        for (int k = 1; k <= WB_STAGE; k++) begin
            slot_v_d[k]  = cur_v[k-1];
            slot_pc_d[k] = cur_pc[k-1];
            slot_st_d[k] = cur_st[k-1];
            slot_sa_d[k] = cur_sa[k-1];
            slot_sd_d[k] = cur_sd[k-1];
        end
        comp_v           = cur_v[WB_STAGE];
        comp_rec.pc      = cur_pc[WB_STAGE];
        comp_rec.seq     = seq_q;
        comp_rec.st      = cur_st[WB_STAGE];
        comp_rec.st_addr = cur_sa[WB_STAGE];
        comp_rec.st_data = cur_sd[WB_STAGE];
        comp_rec.wr      = reg_wr_en;
        comp_rec.wr_num  = reg_wr_en ? reg_wr_num  : 5'd0;
        comp_rec.wr_data = reg_wr_en ? reg_wr_data : 32'd0;
    end

    // Record FIFO; the next head is computed from next-state memory so the output is a flop
    always_comb begin
        deq     = rec_valid_q & rec.rec_ready;
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        enq_try = comp_v & ~done_q;
        enq     = enq_try & (~full | deq);
        drop    = enq_try & full & ~deq;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        seq_d    = seq_q;
        done_d   = done_q;
        if (enq) begin
            mem_d[wr_ptr_q] = comp_rec;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            seq_d           = seq_q + 16'd1;
            count_d         = count_d + CNT_W'(1);
            // Budget is assumed to fit the 16-bit sequence space
            if ((MAX_INSTR != 0) && (seq_q == 16'(MAX_INSTR - 1))) begin
                done_d = 1'b1;
            end else begin
                done_d = done_q;
            end
        end else begin
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_d - CNT_W'(1);
        end else begin
        end
        rec_valid_d = (count_d != '0);
        if (rec_valid_d) begin
            head_d = mem_d[rd_ptr_d];
        end else begin
            head_d = '0;
        end

        overflow_d  = overflow_q | drop;
        drop_cnt_d  = (drop && (drop_cnt_q != 16'hFFFF)) ? (drop_cnt_q + 16'd1) : drop_cnt_q;
        flush_sum   = {1'b0, flush_cnt_q} + {12'd0, flush_hits};
        flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= WB_STAGE; k++) begin
                slot_v_q[k]  <= 1'b0;
                slot_pc_q[k] <= 32'd0;
                slot_st_q[k] <= 1'b0;
                slot_sa_q[k] <= 32'd0;
                slot_sd_q[k] <= 32'd0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seq_q       <= 16'd0;
            rec_valid_q <= 1'b0;
            head_q      <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            for (int k = 1; k <= WB_STAGE; k++) begin
                slot_v_q[k]  <= slot_v_d[k];
                slot_pc_q[k] <= slot_pc_d[k];
                slot_st_q[k] <= slot_st_d[k];
                slot_sa_q[k] <= slot_sa_d[k];
                slot_sd_q[k] <= slot_sd_d[k];
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
            rec_valid_q <= rec_valid_d;
            head_q      <= head_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign rec.rec_valid   = rec_valid_q;
    assign rec.rec_pc      = head_q.pc;
    assign rec.rec_seq     = head_q.seq;
    assign rec.rec_st      = head_q.st;
    assign rec.rec_st_addr = head_q.st_addr;
    assign rec.rec_st_data = head_q.st_data;
    assign rec.rec_wr      = head_q.wr;
    assign rec.rec_wr_num  = head_q.wr_num;
    assign rec.rec_wr_data = head_q.wr_data;
    assign done            = done_q;
    assign overflow        = overflow_q;
    assign drop_cnt        = drop_cnt_q;
    assign flush_cnt       = flush_cnt_q;
endmodule

// File: tb/tb_trace_monitor.sv
// Directed bench for trace_monitor: back-to-back, squash, mid-run reset,
// backpressure with full+dequeue, and the multicycle budget run.
`timescale 1ns/1ps
module tb_trace_monitor;
    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] instr_addr;
    logic        flush;
    logic        st_en;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_num;
    logic [31:0] reg_wr_data;
    logic        done;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [15:0] flush_cnt;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;

    trace_monitor_if rif();

    trace_monitor #(
        .ME_STAGE(3), .WB_STAGE(4), .FIFO_DEPTH(8), .MAX_INSTR(18)
    ) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .instr_addr(instr_addr),
        .flush(flush), .st_en(st_en), .data_addr(data_addr), .data_out(data_out),
        .reg_wr_en(reg_wr_en), .reg_wr_num(reg_wr_num), .reg_wr_data(reg_wr_data),
        .rec(rif), .done(done), .overflow(overflow), .drop_cnt(drop_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %08h expected %08h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(rif.rec_valid), 32'd0);
    endtask

    task automatic chk_rec(input string tag, input logic [31:0] pc, input logic [15:0] seq,
                           input logic st, input logic [31:0] sa, input logic [31:0] sd,
                           input logic wr, input logic [4:0] wn, input logic [31:0] wd);
        chk({tag, ".valid"},   32'(rif.rec_valid),   32'd1);
        chk({tag, ".pc"},      rif.rec_pc,           pc);
        chk({tag, ".seq"},     32'(rif.rec_seq),     32'(seq));
        chk({tag, ".st"},      32'(rif.rec_st),      32'(st));
        chk({tag, ".st_addr"}, rif.rec_st_addr,      sa);
        chk({tag, ".st_data"}, rif.rec_st_data,      sd);
        chk({tag, ".wr"},      32'(rif.rec_wr),      32'(wr));
        chk({tag, ".wr_num"},  32'(rif.rec_wr_num),  32'(wn));
        chk({tag, ".wr_data"}, rif.rec_wr_data,      wd);
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic fl, input logic rdy);
        fetch_valid   = fv;
        instr_addr    = fv ? pc : 32'hDEAD_0000;
        flush         = fl;
        rif.rec_ready = rdy;
        st_en         = 1'b0;
        data_addr     = 32'd0;
        data_out      = 32'd0;
        reg_wr_en     = 1'b0;
        reg_wr_num    = 5'd0;
        reg_wr_data   = 32'd0;
    endtask

    initial begin
        int i;
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        chk_rec_zero: begin
            chk("rst.valid", 32'(rif.rec_valid), 32'd0);
            chk("rst.pc",    rif.rec_pc,         32'd0);
            chk("rst.seq",   32'(rif.rec_seq),   32'd0);
            chk("rst.done",  32'(done),          32'd0);
            chk("rst.ovf",   32'(overflow),      32'd0);
            chk("rst.drop",  32'(drop_cnt),      32'd0);
            chk("rst.flush", 32'(flush_cnt),     32'd0);
        end
        reset = 1'b0;

        // Back-to-back fetches: records in cycles 5..12, seq 0..7
        for (int c = 0; c < 16; c++) begin
            step();
            cyc = c;
            drive((c < 8), 32'h0000_1000 + 32'(4 * c), 1'b0, 1'b1);
            if ((c >= 5) && (c < 13))
                chk_rec("b2b", 32'h0000_1000 + 32'(4 * (c - 5)), 16'(c - 5),
                        1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            else
                chk_idle("b2b");
        end

        // Squash at cycle 4: fetches 2,3,4 cleared, fetch 1 sits in the ME slot and survives
        for (int c = 0; c < 13; c++) begin
            step();
            cyc = c;
            drive((c <= 5), 32'h0000_2000 + 32'(4 * c), (c == 4), 1'b1);
            chk("sq.flush_cnt", 32'(flush_cnt), (c >= 5) ? 32'd3 : 32'd0);
            if (c == 5)
                chk_rec("sq0", 32'h0000_2000, 16'd8, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            else if (c == 6)
                chk_rec("sq1", 32'h0000_2004, 16'd9, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            else if (c == 10)
                chk_rec("sq5", 32'h0000_2014, 16'd10, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            else
                chk_idle("sq");
        end

        // Reset with three instructions in flight; they must never appear
        for (int c = 0; c < 10; c++) begin
            step();
            cyc = c;
            drive((c < 3), 32'h0000_4000 + 32'(4 * c), 1'b0, 1'b1);
            reset = (c == 3);
            chk("rr.flush_cnt", 32'(flush_cnt), (c < 4) ? 32'd3 : 32'd0);
            if (c == 4) begin
                chk("rr.pc",   rif.rec_pc,       32'd0);
                chk("rr.seq",  32'(rif.rec_seq), 32'd0);
                chk("rr.done", 32'(done),        32'd0);
                chk("rr.ovf",  32'(overflow),    32'd0);
                chk("rr.drop", 32'(drop_cnt),    32'd0);
            end
            chk_idle("rr");
        end

        // Backpressure: 12 fetches into 8 entries, then full + same-cycle dequeue at cycle 21
        for (int c = 0; c < 32; c++) begin
            step();
            cyc = c;
            drive((c < 12) || (c == 17), (c == 17) ? 32'h0000_3100 : 32'h0000_3000 + 32'(4 * c),
                  1'b0, (c >= 21));
            chk("bp.drop", 32'(drop_cnt), (c < 13) ? 32'd0 : ((c < 16) ? 32'(c - 12) : 32'd4));
            chk("bp.ovf",  32'(overflow), (c >= 13) ? 32'd1 : 32'd0);
            if ((c >= 5) && (c <= 21))
                chk_rec("bp.hold", 32'h0000_3000, 16'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            else if ((c >= 22) && (c <= 29)) begin
                i = c - 22;
                chk_rec("bp.drain", (i < 7) ? 32'h0000_3004 + 32'(4 * i) : 32'h0000_3100,
                        16'(i + 1), 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            end else
                chk_idle("bp");
        end
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Multicycle cadence: fetch every 5 cycles, 19 fetches against a budget of 18
        for (int c = 0; c <= 100; c++) begin
            step();
            cyc = c;
            drive(((c % 5) == 0) && (c <= 90), 32'h8002_0000 + 32'(4 * (c / 5)), 1'b0, 1'b1);
            if ((c == 13) || (c == 14)) begin
                st_en     = 1'b1;
                data_addr = (c == 13) ? 32'h8012_0000 : 32'hBAD0_0000;
                data_out  = (c == 13) ? 32'h0000_1234 : 32'hBAD1_0000;
            end
            if ((c == 19) || (c == 20)) begin
                reg_wr_en   = 1'b1;
                reg_wr_num  = (c == 19) ? 5'd2 : 5'd7;
                reg_wr_data = (c == 19) ? 32'd5 : 32'hBAD2_0000;
            end
            chk("cad.done", 32'(done), (c >= 90) ? 32'd1 : 32'd0);
            if (((c % 5) == 0) && (c >= 5) && (c <= 90)) begin
                i = (c / 5) - 1;
                chk_rec("cad", 32'h8002_0000 + 32'(4 * i), 16'(i),
                        (i == 2), (i == 2) ? 32'h8012_0000 : 32'd0, (i == 2) ? 32'h0000_1234 : 32'd0,
                        (i == 3), (i == 3) ? 5'd2 : 5'd0, (i == 3) ? 32'd5 : 32'd0);
            end else
                chk_idle("cad");
        end
        chk("cad.ovf",  32'(overflow), 32'd0);
        chk("cad.drop", 32'(drop_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
